ir_transmitter: RTL and testbench

- NEC-format infrared transmitter. It serialises a 32-bit word into a leader, 32 pulse-distance bits and a stop burst.
- It drives a 38 kHz-modulated LED output plus a demodulated envelope output.
- The envelope uses the same polarity the on-board IR receiver block expects (low = burst), so the two blocks can be looped back directly.
- Timing constants assume a 50 MHz clock (1 cycle = 0.02 us).

---
 rtl/ir_pkg.sv | 34 +++
 rtl/ir_carrier_gen.sv | 55 +++++
 rtl/ir_transmitter.sv | 160 ++++++++++++++++
 tb/tb_ir_transmitter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/ir_pkg.sv
// Shared NEC infrared definitions: default timing and transmitter state encoding.
// Latency: n/a (constants and helpers only).
// Backpressure: n/a.
//
// All durations are in clock cycles of a 50 MHz reference clock,
// where one cycle is 20 ns (0.02 us). The receiver derives its
// thresholds from the same defaults.
package ir_pkg;

    // NEC frame timing defaults at 50 MHz.
    localparam int NEC_LEADER_MARK_DUR  = 450_000;    // 9.0 ms
    localparam int NEC_LEADER_SPACE_DUR = 225_000;    // 4.5 ms
    localparam int NEC_BIT_MARK_DUR     = 28_125;     // 562.5 us
    localparam int NEC_ZERO_SPACE_DUR   = 28_125;     // 562.5 us
    localparam int NEC_ONE_SPACE_DUR    = 84_375;     // 1.6875 ms
    localparam int NEC_GAP_DUR          = 2_000_000;  // 40 ms guard
    localparam int NEC_CARRIER_HALF     = 658;        // ~38 kHz carrier
    localparam int NEC_CNT_W            = 22;

    // Transmitter state encoding (kept as plain constants for legacy tools).
    localparam logic [2:0] ST_IDLE         = 3'd0;
    localparam logic [2:0] ST_LEADER_MARK  = 3'd1;
    localparam logic [2:0] ST_LEADER_SPACE = 3'd2;
    localparam logic [2:0] ST_BIT_MARK     = 3'd3;
    localparam logic [2:0] ST_BIT_SPACE    = 3'd4;
    localparam logic [2:0] ST_STOP_MARK    = 3'd5;
    localparam logic [2:0] ST_GAP          = 3'd6;

    // A mark is any state in which the carrier burst is on the air.
    function automatic logic is_mark_state(input logic [2:0] st);
        return (st == ST_LEADER_MARK) || (st == ST_BIT_MARK) || (st == ST_STOP_MARK);
    endfunction

endpackage

// File: rtl/ir_carrier_gen.sv
// Carrier generator: square wave starting high for CARRIER_HALF cycles, then toggling.
// Latency: registered; output reflects enable/restart from the same edge they are sampled.
// Backpressure: none; free-running while enabled, forced low and phase cleared when disabled.
module ir_carrier_gen
    import ir_pkg::*;
#(
    parameter int CARRIER_HALF = NEC_CARRIER_HALF
)
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic enable_i,
    input  logic restart_i,
    output logic carrier_o
);

    localparam int PH_W = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(CARRIER_HALF - 1);

    logic [PH_W-1:0] phase_q, phase_d;
    logic            car_q, car_d;

    // Next phase/level: restart forces a fresh high half-period, otherwise
    // toggle each time the phase counter completes a half-period.
    always_comb begin
        phase_d = phase_q;
        car_d   = car_q;
        if (!enable_i) begin
            phase_d = '0;
            car_d   = 1'b0;
        end else if (restart_i) begin
            phase_d = '0;
            car_d   = 1'b1;
        end else if (phase_q == PH_LAST) begin
            phase_d = '0;
            car_d   = ~car_q;
        end else begin
            phase_d = phase_q + PH_W'(1);
        end
    end

    // Carrier state registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            phase_q <= '0;
            car_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            car_q   <= car_d;
        end
    end

    assign carrier_o = car_q;

endmodule

// File: rtl/ir_transmitter.sv
// NEC IR transmitter: leader, 32 LSB-first pulse-distance bits, stop burst, guard gap.
// Latency: envelope falls on the edge that accepts i_SEND (visible one cycle later).
// Backpressure: i_SEND is ignored while o_BUSY is high; no queueing of requests.
module ir_transmitter
    import ir_pkg::*;
#(
    parameter int LEADER_MARK_DUR  = NEC_LEADER_MARK_DUR,
    parameter int LEADER_SPACE_DUR = NEC_LEADER_SPACE_DUR,
    parameter int BIT_MARK_DUR     = NEC_BIT_MARK_DUR,
    parameter int ZERO_SPACE_DUR   = NEC_ZERO_SPACE_DUR,
    parameter int ONE_SPACE_DUR    = NEC_ONE_SPACE_DUR,
    parameter int GAP_DUR          = NEC_GAP_DUR,
    parameter int CARRIER_HALF     = NEC_CARRIER_HALF,
    parameter int CNT_W            = NEC_CNT_W
)
(
    input  logic        i_CLOCK_POS,
    input  logic        i_RESET_POS,
    input  logic        i_SEND,
    input  logic [31:0] i_DATA,
    output logic        o_BUSY,
    output logic        o_DONE,
    output logic        o_IRDA_ENV,
    output logic        o_IR_LED
);

    // Terminal counts: a segment exits when the counter reaches DUR-1.
    localparam logic [CNT_W-1:0] LM_LAST   = CNT_W'(LEADER_MARK_DUR - 1);
    localparam logic [CNT_W-1:0] LS_LAST   = CNT_W'(LEADER_SPACE_DUR - 1);
    localparam logic [CNT_W-1:0] BM_LAST   = CNT_W'(BIT_MARK_DUR - 1);
    localparam logic [CNT_W-1:0] ZERO_LAST = CNT_W'(ZERO_SPACE_DUR - 1);
    localparam logic [CNT_W-1:0] ONE_LAST  = CNT_W'(ONE_SPACE_DUR - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_DUR - 1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [5:0]       bit_cnt_q, bit_cnt_d;
    logic [31:0]      shift_q, shift_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             env_q, env_d;

    logic [CNT_W-1:0] seg_last_val;
    logic             seg_last;
    logic             car_en;
    logic             car_restart;

    // Terminal count of the current segment; a bit space length follows the pending LSB.
    always_comb begin
        seg_last_val = '0;
        case (state_q)
            ST_LEADER_MARK:  seg_last_val = LM_LAST;
            ST_LEADER_SPACE: seg_last_val = LS_LAST;
            ST_BIT_MARK:     seg_last_val = BM_LAST;
            ST_BIT_SPACE:    seg_last_val = shift_q[0] ? ONE_LAST : ZERO_LAST;
            ST_STOP_MARK:    seg_last_val = BM_LAST;
            ST_GAP:          seg_last_val = GAP_LAST;
            default:         seg_last_val = '0;
        endcase
    end

    assign seg_last = (cnt_q == seg_last_val);

    // Frame sequencer: state, shift register and bit counter next-state.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        case (state_q)
            ST_IDLE: begin
                bit_cnt_d = '0;
                if (i_SEND) begin
                    state_d = ST_LEADER_MARK;
                    shift_d = i_DATA;
                end
            end
            ST_LEADER_MARK: begin
                if (seg_last) state_d = ST_LEADER_SPACE;
            end
            ST_LEADER_SPACE: begin
                if (seg_last) state_d = ST_BIT_MARK;
            end
            ST_BIT_MARK: begin
                if (seg_last) state_d = ST_BIT_SPACE;
            end
            ST_BIT_SPACE: begin
                if (seg_last) begin
                    shift_d   = {1'b0, shift_q[31:1]};
                    bit_cnt_d = bit_cnt_q + 6'd1;
                    state_d   = (bit_cnt_q == 6'd31) ? ST_STOP_MARK : ST_BIT_MARK;
                end
            end
            ST_STOP_MARK: begin
                if (seg_last) state_d = ST_GAP;
            end
            ST_GAP: begin
                if (seg_last) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Duration counter restarts on every state change and idles at zero.
    always_comb begin
        if ((state_d != state_q) || (state_q == ST_IDLE)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Outputs are computed from the next state so they register on the same
    // edge as the state they describe; done marks the final stop-burst cycle.
    always_comb begin
        busy_d = (state_d != ST_IDLE);
        env_d  = ~is_mark_state(state_d);
        done_d = (state_d == ST_STOP_MARK) && (cnt_d == BM_LAST);
    end

    assign car_en      = is_mark_state(state_d);
    assign car_restart = is_mark_state(state_d) && !is_mark_state(state_q);

    // Sequencer, counters and registered outputs with synchronous reset.
    always_ff @(posedge i_CLOCK_POS) begin
        if (i_RESET_POS) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            env_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            env_q     <= env_d;
        end
    end

    ir_carrier_gen #(
        .CARRIER_HALF (CARRIER_HALF)
    ) u_carrier (
        .clk_i     (i_CLOCK_POS),
        .rst_i     (i_RESET_POS),
        .enable_i  (car_en),
        .restart_i (car_restart),
        .carrier_o (o_IR_LED)
    );

    assign o_BUSY     = busy_q;
    assign o_DONE     = done_q;
    assign o_IRDA_ENV = env_q;

endmodule

// File: tb/tb_ir_transmitter.sv
// Self-checking bench for ir_transmitter using timing scaled down by 1000.
// Latency: n/a.
// Backpressure: n/a.
module tb_ir_transmitter;

    // Frame timing for the main instance (NEC defaults divided by 1000).
    localparam int LM   = 450;
    localparam int LS   = 225;
    localparam int BM   = 28;
    localparam int ZS   = 28;
    localparam int OS   = 84;
    localparam int GAP  = 2000;
    localparam int HALF = 2;

    logic        clk;
    logic        rst;
    logic        send;
    logic [31:0] data;
    logic        busy, done, env, led;
    logic        send2;
    logic [31:0] data2;
    logic        busy2, done2, env2, led2;

    int checks   = 0;
    int failures = 0;

    ir_transmitter #(
        .LEADER_MARK_DUR (LM), .LEADER_SPACE_DUR (LS), .BIT_MARK_DUR (BM),
        .ZERO_SPACE_DUR (ZS), .ONE_SPACE_DUR (OS), .GAP_DUR (GAP),
        .CARRIER_HALF (HALF), .CNT_W (22)
    ) dut (
        .i_CLOCK_POS (clk), .i_RESET_POS (rst), .i_SEND (send), .i_DATA (data),
        .o_BUSY (busy), .o_DONE (done), .o_IRDA_ENV (env), .o_IR_LED (led)
    );

    // Small-timing instance for exact carrier pattern checks.
    ir_transmitter #(
        .LEADER_MARK_DUR (30), .LEADER_SPACE_DUR (15), .BIT_MARK_DUR (12),
        .ZERO_SPACE_DUR (12), .ONE_SPACE_DUR (36), .GAP_DUR (50),
        .CARRIER_HALF (3), .CNT_W (22)
    ) dut2 (
        .i_CLOCK_POS (clk), .i_RESET_POS (rst), .i_SEND (send2), .i_DATA (data2),
        .o_BUSY (busy2), .o_DONE (done2), .o_IRDA_ENV (env2), .o_IR_LED (led2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Sends one word (caller is at a negedge) and measures the envelope.
    // inj=1 pulses a second i_SEND and alters i_DATA partway through the frame.
    task automatic run_frame(input logic [31:0] d, input int inj, input int exp_len,
                             input string tag);
        int          runs[$];
        int          cur_len, t, done_t, done_cnt, busy_low_t, led_bad, mark_bad, sp_bad;
        logic        cur_env;
        logic [31:0] word;
        data = d;
        send = 1'b1;
        @(posedge clk);
        @(negedge clk);
        send = 1'b0;
        chk({tag, "_env_latency"}, env, 0);
        chk({tag, "_busy_after_accept"}, busy, 1);
        t = 0; done_t = -1; done_cnt = 0; busy_low_t = -1; led_bad = 0;
        cur_env = env; cur_len = 0; word = '0; mark_bad = 0; sp_bad = 0;
        while (t < exp_len + GAP + 100) begin
            if (busy == 1'b0) begin
                busy_low_t = t;
                break;
            end
            if (env !== cur_env) begin
                runs.push_back(cur_len);
                cur_env = env;
                cur_len = 0;
            end
            cur_len++;
            if (done === 1'b1) begin
                done_cnt++;
                done_t = t;
            end
            if (env === 1'b1 && led !== 1'b0) led_bad++;
            if (inj == 1 && t == 1000) begin
                send = 1'b1;
                data = ~d;
            end
            if (inj == 1 && t == 1001) send = 1'b0;
            t++;
            @(negedge clk);
        end
        runs.push_back(cur_len);
        chk({tag, "_busy_drop_seen"}, (busy_low_t >= 0), 1);
        chk({tag, "_frame_len"}, done_t + 1, exp_len);
        chk({tag, "_done_pulses"}, done_cnt, 1);
        chk({tag, "_busy_after_done"}, busy_low_t - done_t - 1, GAP);
        chk({tag, "_led_in_space"}, led_bad, 0);
        chk({tag, "_run_count"}, runs.size(), 68);
        if (runs.size() == 68) begin
            chk({tag, "_leader_mark"}, runs[0], LM);
            chk({tag, "_leader_space"}, runs[1], LS);
            for (int i = 0; i < 32; i++) begin
                if (runs[2 + 2 * i] != BM) mark_bad++;
                if (runs[3 + 2 * i] != ZS && runs[3 + 2 * i] != OS) sp_bad++;
                word[i] = (runs[3 + 2 * i] > (ZS + OS) / 2);
            end
            chk({tag, "_bit_marks"}, mark_bad, 0);
            chk({tag, "_bit_spaces"}, sp_bad, 0);
            chk({tag, "_stop_mark"}, runs[66], BM);
            chk({tag, "_decoded_word"}, word, d);
        end
    endtask

    typedef struct {
        logic [31:0] data;
        int          inj;
        int          exp_len;
        string       tag;
    } vec_t;

    vec_t tbl[4];

    initial begin : main
        int          idle_bad, falls, t, p, marks, car_bad, sp_bad, start_bad, done_cnt;
        logic        prev_env, exp_led;
        logic [11:0] pat;

        // Frame length = 675 + 32*28 + spaces + 28 (scaled cycles).
        // All zero: 675+896+32*28+28 = 2495. All one: 675+896+32*84+28 = 4287.
        // 0x00FF20DF has 16 ones: 675+896+16*28+16*84+28 = 3391.
        tbl[0] = '{32'h0000_0000, 0, 2495, "zeros"};
        tbl[1] = '{32'hFFFF_FFFF, 0, 4287, "ones"};
        tbl[2] = '{32'h00FF_20DF, 0, 3391, "nec_word"};
        tbl[3] = '{32'h00FF_20DF, 1, 3391, "ignore_midframe"};

        rst = 1'b1; send = 1'b0; data = '0; send2 = 1'b0; data2 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_env", env, 1);
        chk("reset_led", led, 0);

        idle_bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || done !== 1'b0 || env !== 1'b1 || led !== 1'b0) idle_bad++;
        end
        chk("idle_outputs", idle_bad, 0);

        // Rows run back to back: each send lands on the first cycle busy is low.
        for (int i = 0; i < 4; i++) begin
            run_frame(tbl[i].data, tbl[i].inj, tbl[i].exp_len, tbl[i].tag);
        end

        // Reset in the middle of bit 10 (12th envelope fall: leader + bits 0..10).
        data = 32'h1234_5678;
        send = 1'b1;
        @(posedge clk);
        @(negedge clk);
        send = 1'b0;
        falls = 0; prev_env = 1'b1; t = 0;
        while (falls < 12 && t < 5000) begin
            if (prev_env === 1'b1 && env === 1'b0) falls++;
            prev_env = env;
            t++;
            @(negedge clk);
        end
        chk("reset_mid_reached_bit10", falls, 12);
        repeat (5) @(negedge clk);
        chk("reset_mid_busy_before", busy, 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("reset_mid_env", env, 1);
        chk("reset_mid_led", led, 0);
        chk("reset_mid_busy", busy, 0);
        chk("reset_mid_done", done, 0);
        rst = 1'b0;
        @(negedge clk);
        // 0xA5C30F96 has 16 ones -> 3391 cycles.
        run_frame(32'hA5C3_0F96, 0, 3391, "after_reset");

        // Carrier pattern on the small instance: half period 3, bit mark 12.
        data2 = 32'h0000_0003;
        send2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        send2 = 1'b0;
        prev_env = 1'b1; p = 0; marks = 0; car_bad = 0; sp_bad = 0; start_bad = 0;
        done_cnt = 0; t = 0; pat = '0;
        while (busy2 === 1'b1 && t < 5000) begin
            if (env2 === 1'b0) begin
                if (prev_env === 1'b1) begin
                    marks++;
                    p = 0;
                    if (led2 !== 1'b1) start_bad++;
                end
                exp_led = (((p / 3) % 2) == 0);
                if (led2 !== exp_led) car_bad++;
                if (marks == 2 && p < 12) pat[11 - p] = led2;
                p++;
            end else if (led2 !== 1'b0) begin
                sp_bad++;
            end
            if (done2 === 1'b1) done_cnt++;
            prev_env = env2;
            t++;
            @(negedge clk);
        end
        chk("carrier_frame_ended", busy2, 0);
        chk("carrier_mark_count", marks, 34);
        chk("carrier_first_bit_pattern", pat, 12'b111000111000);
        chk("carrier_waveform", car_bad, 0);
        chk("carrier_mark_start_high", start_bad, 0);
        chk("carrier_zero_in_space", sp_bad, 0);
        chk("carrier_done_pulses", done_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
